// File: rtl/popcount_accum.sv
// Frame-level ones counter: counts set bits per input word and accumulates
// the counts and beats of each din_last-delimited frame into a held result.
module popcount_accum #(
    parameter int WL     = 32,
    parameter int SUM_W  = 16,
    parameter int BEAT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [WL-1:0]     din,
    input  logic              din_last,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic [SUM_W-1:0]  sum,
    output logic [BEAT_W-1:0] beats,
    output logic              sat
);

    localparam int CNT_W = $clog2(WL + 1);

    // valid/ready: a word transfers on a rising edge where din_valid && din_ready;
    // the result transfers where sum_valid && sum_ready. sum/beats/sat hold
    // while sum_valid is high and sum_ready is low, and the whole pipe freezes.
    logic                w_en;
    logic [CNT_W-1:0]    w_pop;

    logic                r_a_valid;
    logic [CNT_W-1:0]    r_a_cnt;
    logic                r_a_last;

    logic [SUM_W-1:0]    r_acc;
    logic [BEAT_W-1:0]   r_bcnt;
    logic                r_sat_acc;

    logic                r_sum_valid;
    logic [SUM_W-1:0]    r_sum;
    logic [BEAT_W-1:0]   r_beats;
    logic                r_sat;

    logic [SUM_W:0]      w_nsum_wide;
    logic                w_sum_sat;
    logic [SUM_W-1:0]    w_nsum;
    logic                w_beat_sat;
    logic [BEAT_W-1:0]   w_nbeats;
    logic                w_nsat;

    assign w_en      = !(r_sum_valid && !sum_ready);
    assign din_ready = w_en && !rst;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WL; i++) begin
            w_pop = w_pop + CNT_W'(din[i]);
        end
    end

    // Stage A: register the word's popcount and frame marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_a_cnt   <= '0;
            r_a_last  <= 1'b0;
        end else if (w_en) begin
            r_a_valid <= din_valid && din_ready;
            r_a_cnt   <= w_pop;
            r_a_last  <= din_last;
        end
    end

    // Stage B arithmetic: one extra bit on the sum exposes the overflow.
    always_comb begin
        w_nsum_wide = {1'b0, r_acc} + (SUM_W + 1)'(r_a_cnt);
        w_sum_sat   = w_nsum_wide[SUM_W];
        w_nsum      = w_sum_sat ? {SUM_W{1'b1}} : w_nsum_wide[SUM_W-1:0];
        w_beat_sat  = &r_bcnt;
        w_nbeats    = w_beat_sat ? r_bcnt : r_bcnt + BEAT_W'(1);
        w_nsat      = r_sat_acc || w_sum_sat || w_beat_sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_bcnt      <= '0;
            r_sat_acc   <= 1'b0;
            r_sum_valid <= 1'b0;
            r_sum       <= '0;
            r_beats     <= '0;
            r_sat       <= 1'b0;
        end else if (w_en) begin
            // w_en with sum_valid high means the result is being taken now.
            if (r_sum_valid) begin
                r_sum_valid <= 1'b0;
            end
            if (r_a_valid) begin
                if (r_a_last) begin
                    r_sum       <= w_nsum;
                    r_beats     <= w_nbeats;
                    r_sat       <= w_nsat;
                    r_sum_valid <= 1'b1;
                    r_acc       <= '0;
                    r_bcnt      <= '0;
                    r_sat_acc   <= 1'b0;
                end else begin
                    r_acc     <= w_nsum;
                    r_bcnt    <= w_nbeats;
                    r_sat_acc <= w_nsat;
                end
            end
        end
    end

    assign sum_valid = r_sum_valid;
    assign sum       = r_sum;
    assign beats     = r_beats;
    assign sat       = r_sat;

endmodule
